// File: rtl/mp_job_dispatcher_if.sv
// Handshake and kernel-side bus of the job dispatcher.
// Signal names keep their _i/_o suffixes as seen from the dispatcher (slave modport).
interface mp_job_dispatcher_if #(
    parameter int KERNEL_NUM = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                  process_start_i;
    logic [87:0]           process_info_i;
    logic                  process_ready_o;
    logic [KERNEL_NUM-1:0] kernel_start_o;
    logic [87:0]           kernel_info_o;
    logic [KERNEL_NUM-1:0] kernel_idle_i;
    logic [KERNEL_NUM-1:0] kernel_done_i;
    logic [KERNEL_NUM-1:0] busy_vec_o;
    logic [CW-1:0]         fifo_count_o;
    logic                  spurious_done_o;
    logic [31:0]           dispatch_cnt_o;
    logic [31:0]           cmpl_cnt_o;

    modport slave (
        input  process_start_i, process_info_i, kernel_idle_i, kernel_done_i,
        output process_ready_o, kernel_start_o, kernel_info_o, busy_vec_o,
               fifo_count_o, spurious_done_o, dispatch_cnt_o, cmpl_cnt_o
    );

    modport master (
        output process_start_i, process_info_i, kernel_idle_i, kernel_done_i,
        input  process_ready_o, kernel_start_o, kernel_info_o, busy_vec_o,
               fifo_count_o, spurious_done_o, dispatch_cnt_o, cmpl_cnt_o
    );
endinterface

// File: rtl/mp_job_dispatcher.sv
// Job FIFO feeding a round-robin issuer that pulses one idle kernel per job and tracks busy kernels.
// Optional dispatch/completion counters are built when MP_DISPATCH_STATS_EN is defined.
module mp_job_dispatcher #(
    parameter int  KERNEL_NUM = 8,
    parameter int  FIFO_DEPTH = 16,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input logic               clk,
    input logic               rst_n,
    mp_job_dispatcher_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int KW = $clog2(KERNEL_NUM);

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t                state;
    logic [87:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count, count_next;
    logic                  ready_q, spurious_q, push, pop, grant_found;
    logic [KERNEL_NUM-1:0] busy, elig, grant_vec, start_q;
    logic [87:0]           info_q;
    logic [KW-1:0]         rr_ptr, grant_idx, cand;

    assign push = bus.process_start_i & ready_q;
    // A kernel finishing this cycle is held off until its busy bit has cleared.
    assign elig = bus.kernel_idle_i & ~busy & ~bus.kernel_done_i;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < KERNEL_NUM; i++) begin
            cand = KW'((int'(rr_ptr) + i) % KERNEL_NUM);
            if (!grant_found && elig[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign pop        = (state == S_IDLE) && (count != '0) && grant_found;
    assign grant_vec  = pop ? (KERNEL_NUM'(1) << grant_idx) : '0;
    assign count_next = count + CW'(push) - CW'(pop);

    // NOTE: the storage array has no reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.process_info_i;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ready_q    <= 1'b1;
            busy       <= '0;
            spurious_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count   <= count_next;
            ready_q <= (count_next != CW'(FIFO_DEPTH));
            busy    <= (busy & ~bus.kernel_done_i) | grant_vec;
            if (|(bus.kernel_done_i & ~busy)) spurious_q <= 1'b1;
        end
    end

    // The issue state gives a started kernel one cycle to drop its idle flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            start_q <= '0;
            info_q  <= '0;
            rr_ptr  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        start_q <= grant_vec;
                        info_q  <= mem[rd_ptr];
                        rr_ptr  <= (grant_idx == KW'(KERNEL_NUM - 1)) ? '0 : grant_idx + KW'(1);
                        state   <= S_ISSUE;
                    end else begin
                        start_q <= '0;
                    end
                end
                S_ISSUE: begin
                    start_q <= '0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MP_DISPATCH_STATS_EN
    logic [31:0] dispatch_cnt, cmpl_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dispatch_cnt <= '0;
            cmpl_cnt     <= '0;
        end else begin
            dispatch_cnt <= dispatch_cnt + 32'(pop);
            cmpl_cnt     <= cmpl_cnt + 32'($countones(bus.kernel_done_i & busy));
        end
    end

    assign bus.dispatch_cnt_o = dispatch_cnt;
    assign bus.cmpl_cnt_o     = cmpl_cnt;
`else
    assign bus.dispatch_cnt_o = '0;
    assign bus.cmpl_cnt_o     = '0;
`endif

    assign bus.process_ready_o = ready_q;
    assign bus.kernel_start_o  = start_q;
    assign bus.kernel_info_o   = info_q;
    assign bus.busy_vec_o      = busy;
    assign bus.fifo_count_o    = count;
    assign bus.spurious_done_o = spurious_q;
endmodule

// File: tb/tb_mp_job_dispatcher.sv
// Randomized and directed bench for mp_job_dispatcher against a queue-based reference model.
// Honours MP_DISPATCH_STATS_EN for the expected counter values.
module tb_mp_job_dispatcher;
    localparam int K     = 8;
    localparam int DEPTH = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    mp_job_dispatcher_if #(.KERNEL_NUM(K), .FIFO_DEPTH(DEPTH)) bus ();

    mp_job_dispatcher #(.KERNEL_NUM(K), .FIFO_DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: pending jobs, busy kernels, round-robin origin.
    logic [87:0]  m_q[$];
    logic [K-1:0] m_busy, m_start;
    logic [87:0]  m_info;
    logic         m_spur, m_last;
    int           m_rr;
    logic [31:0]  m_disp, m_cmpl;
    int           timer[K];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_busy = '0; m_start = '0; m_info = '0;
        m_spur = 1'b0; m_last = 1'b0; m_rr = 0;
        m_disp = '0; m_cmpl = '0;
    endtask

    // One clock edge of the dispatcher's rules, using the inputs present at that edge.
    task automatic model_step();
        logic [K-1:0] done, old_busy, elig;
        bit push;
        int g;
        done     = bus.kernel_done_i;
        old_busy = m_busy;
        push     = bus.process_start_i && (m_q.size() != DEPTH);
        elig     = bus.kernel_idle_i & ~old_busy & ~done;
        m_start  = '0;
        if (!m_last && m_q.size() > 0 && elig != '0) begin
            g = -1;
            for (int i = 0; i < K; i++)
                if (g < 0 && ((elig >> ((m_rr + i) % K)) & K'(1)) != '0) g = (m_rr + i) % K;
            m_start = K'(1) << g;
            m_info  = m_q.pop_front();
            m_rr    = (g + 1) % K;
            m_disp  = m_disp + 1;
        end
        m_last = (m_start != '0);
        if ((done & ~old_busy) != '0) m_spur = 1'b1;
        m_cmpl = m_cmpl + 32'($countones(done & old_busy));
        m_busy = (old_busy & ~done) | m_start;
        if (push) m_q.push_back(bus.process_info_i);
    endtask

    task automatic compare_all();
        check("ready", bus.process_ready_o, m_q.size() != DEPTH);
        check("start", bus.kernel_start_o, m_start);
        check("info", bus.kernel_info_o, m_info);
        check("busy", bus.busy_vec_o, m_busy);
        check("count", bus.fifo_count_o, m_q.size());
        check("spurious", bus.spurious_done_o, m_spur);
`ifdef MP_DISPATCH_STATS_EN
        check("dispatch_cnt", bus.dispatch_cnt_o, m_disp);
        check("cmpl_cnt", bus.cmpl_cnt_o, m_cmpl);
`else
        check("dispatch_cnt", bus.dispatch_cnt_o, 0);
        check("cmpl_cnt", bus.cmpl_cnt_o, 0);
`endif
    endtask

    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else        model_step();
        #1;
        compare_all();
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.process_start_i = 1'b0; bus.process_info_i = '0;
        bus.kernel_idle_i = '0; bus.kernel_done_i = '0;
        for (int k = 0; k < K; k++) timer[k] = 0;
        #1;
        check("rst_ready", bus.process_ready_o, 1);
        check("rst_start", bus.kernel_start_o, 0);
        check("rst_info", bus.kernel_info_o, 0);
        check("rst_busy", bus.busy_vec_o, 0);
        check("rst_count", bus.fifo_count_o, 0);
        check("rst_spurious", bus.spurious_done_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Each kernel runs a started job for a random number of cycles, then pulses done.
    task automatic kernel_tick(input bit spur);
        logic [K-1:0] d, idl;
        d = '0; idl = '0;
        for (int k = 0; k < K; k++) begin
            if (timer[k] > 0) begin
                timer[k]--;
                if (timer[k] == 0) d |= K'(1) << k;
            end
            if (bus.kernel_start_o[k]) timer[k] = $urandom_range(1, 12);
            if (timer[k] == 0 && $urandom_range(0, 7) != 0) idl |= K'(1) << k;
        end
        if (spur && $urandom_range(0, 99) == 0) d |= K'(1) << $urandom_range(0, K - 1);
        bus.kernel_done_i = d;
        bus.kernel_idle_i = idl;
    endtask

    task automatic run_random(input int cycles, input int max_jobs, input bit spur,
                              input int reset_at, output bit drained);
        int sent = 0;
        bit p_start = 1'b0, p_ready = 1'b0;
        drained = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (c == reset_at) begin
                do_reset();
                p_start = 1'b0;
                continue;
            end
            if (p_start && p_ready) sent++;
            kernel_tick(spur);
            if (!(p_start && !p_ready)) begin
                if (sent < max_jobs && $urandom_range(0, 2) != 0) begin
                    bus.process_start_i = 1'b1;
                    bus.process_info_i  = {7'b0, 17'($urandom), $urandom, $urandom};
                end else begin
                    bus.process_start_i = 1'b0;
                end
            end
            p_start = bus.process_start_i;
            p_ready = bus.process_ready_o;
            if (sent >= max_jobs && !bus.process_start_i && bus.fifo_count_o == 0 &&
                bus.busy_vec_o == '0 && bus.kernel_start_o == '0) begin
                drained = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit drained;
        int n;
        bus.process_start_i = 1'b0; bus.process_info_i = '0;
        bus.kernel_idle_i = '0; bus.kernel_done_i = '0;
        do_reset();

        // Single job with every kernel idle: start on kernel 0 two cycles after the push.
        bus.kernel_idle_i = '1;
        bus.process_start_i = 1'b1;
        bus.process_info_i  = 88'h0_12_034_00000000_DEAD0000;
        @(negedge clk);
        bus.process_start_i = 1'b0;
        @(posedge clk); #2;
        check("single_start", bus.kernel_start_o, 8'h01);
        check("single_info", bus.kernel_info_o, 88'h0_12_034_00000000_DEAD0000);
        check("single_busy", bus.busy_vec_o, 8'h01);

        // Round robin over all kernels, then stall with two jobs left; kernel 3 frees up.
        do_reset();
        bus.kernel_idle_i = '1;
        for (int i = 0; i < 10; i++) begin
            bus.process_start_i = 1'b1;
            bus.process_info_i  = 88'(i + 100);
            @(negedge clk);
        end
        bus.process_start_i = 1'b0;
        repeat (30) @(negedge clk);
        check("rr_busy_all", bus.busy_vec_o, 8'hFF);
        check("rr_count", bus.fifo_count_o, 2);
        bus.kernel_done_i = 8'h08;
        @(negedge clk);
        bus.kernel_done_i = '0;
        n = 0;
        while (bus.kernel_start_o == '0 && n < 6) begin @(negedge clk); n++; end
        check("rr_restart_k3", bus.kernel_start_o, 8'h08);

        // Fill the FIFO with no eligible kernel; a held 17th job waits for one pop.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            bus.process_start_i = 1'b1;
            bus.process_info_i  = 88'(i + 200);
            @(negedge clk);
        end
        check("full_ready", bus.process_ready_o, 0);
        check("full_count", bus.fifo_count_o, 16);
        bus.process_info_i = 88'h217;
        repeat (3) @(negedge clk);
        check("full_hold_count", bus.fifo_count_o, 16);
        bus.kernel_idle_i = 8'h01;
        @(negedge clk);
        bus.kernel_idle_i = '0;
        check("full_ready_back", bus.process_ready_o, 1);
        @(negedge clk);
        bus.process_start_i = 1'b0;
        check("full_refill_count", bus.fifo_count_o, 16);
        check("full_refill_ready", bus.process_ready_o, 0);

        // Done on kernel 5 in the cycle it would otherwise be granted.
        do_reset();
        bus.kernel_idle_i = 8'h20;
        for (int i = 0; i < 3; i++) begin
            bus.process_start_i = 1'b1;
            bus.process_info_i  = 88'(i + 300);
            @(negedge clk);
        end
        bus.process_start_i = 1'b0;
        repeat (6) @(negedge clk);
        check("coll_busy5", bus.busy_vec_o, 8'h20);
        bus.kernel_done_i = 8'h20;
        @(posedge clk); #2;
        check("coll_no_grant", bus.kernel_start_o, 8'h00);
        check("coll_busy_clr", bus.busy_vec_o, 8'h00);
        @(negedge clk);
        bus.kernel_done_i = '0;
        @(posedge clk); #2;
        check("coll_grant5", bus.kernel_start_o, 8'h20);

        // Spurious done on an idle kernel is sticky until reset.
        do_reset();
        bus.kernel_done_i = 8'h04;
        @(negedge clk);
        bus.kernel_done_i = '0;
        check("spur_set", bus.spurious_done_o, 1);
        check("spur_busy", bus.busy_vec_o, 8'h00);
        repeat (3) @(negedge clk);
        check("spur_sticky", bus.spurious_done_o, 1);
        do_reset();

        // Twenty jobs issued and completed.
        run_random(3000, 20, 1'b0, -1, drained);
        check("stats_drained", drained, 1);
`ifdef MP_DISPATCH_STATS_EN
        check("stats_dispatch20", bus.dispatch_cnt_o, 20);
        check("stats_cmpl20", bus.cmpl_cnt_o, 20);
`else
        check("stats_dispatch0", bus.dispatch_cnt_o, 0);
        check("stats_cmpl0", bus.cmpl_cnt_o, 0);
`endif

        // Long random run with occasional spurious dones and a reset mid-traffic.
        do_reset();
        run_random(4000, 1000000, 1'b1, 2000, drained);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mp_job_dispatcher.md
# mp_job_dispatcher

Job dispatcher directly downstream of the AXI-Lite job-control block. Accepts 88-bit job descriptors (`process_start`/`process_info`/`process_ready` handshake) into a FIFO. Issues each job as a one-cycle start pulse to one idle kernel, choosing kernels round-robin. Tracks per-kernel busy state until each kernel reports completion.

## Interface
Parameters:
- `KERNEL_NUM`, 8 — number of kernel engines, 2..16.
- `FIFO_DEPTH`, 16 — job FIFO entries; power of two, ≥2.
- `CW` — derived, `$clog2(FIFO_DEPTH)+1`; count width.

Ports:
- `clk`  in  1  — single clock.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `process_start_i`  in  1  — upstream job valid; level, held until accepted.
- `process_info_i`  in  88  — `{7'b0, ctrl[7:0], process_id[8:0], init_addr[63:0]}`.
- `process_ready_o`  out  1  — FIFO can accept; registered.
- `kernel_start_o`  out  KERNEL_NUM  — one-hot, one-cycle start pulse.
- `kernel_info_o`  out  88  — descriptor for the kernel being started; shared by all kernels.
- `kernel_idle_i`  in  KERNEL_NUM  — kernel k can accept a job.
- `kernel_done_i`  in  KERNEL_NUM  — one-cycle completion pulse per kernel.
- `busy_vec_o`  out  KERNEL_NUM  — kernels holding an issued, uncompleted job.
- `fifo_count_o`  out  CW  — jobs queued.
- `spurious_done_o`  out  1  — sticky; set by a done pulse on a non-busy kernel.
- `dispatch_cnt_o`  out  32  — jobs issued; present only under the macro.
- `cmpl_cnt_o`  out  32  — completions; present only under the macro.

## Operation
- Accept:
  - A push occurs in any cycle with `process_start_i & process_ready_o`.
  - `process_ready_o` is computed from the registered count: `ready = (count != FIFO_DEPTH)`.
  - A push is never accepted while full, even if a pop occurs in the same cycle.
- FIFO:
  - Register array with wrapping read/write pointers.
  - The head is visible the cycle after its push.
  - Simultaneous push and pop leaves the count unchanged.
- Eligibility: `elig = kernel_idle_i & ~busy & ~kernel_done_i`. A kernel whose done pulse arrives this cycle is not eligible until the next cycle.
- Arbitration: grant = first set bit of `elig`, searching from `rr_ptr` upward and wrapping modulo KERNEL_NUM. After a grant, `rr_ptr <= grant+1` (wraps to 0).
- FSM:
  - S_IDLE: if `count != 0` and `elig != 0`, then register `kernel_start_o[g]=1` and `kernel_info_o=head`, set `busy[g]`, pop, go to S_ISSUE. Otherwise stay in S_IDLE.
  - S_ISSUE: `kernel_start_o=0`; go to S_IDLE unconditionally. This state absorbs kernel idle-deassert latency.
- Busy tracking:
  - `busy[k]` is set on grant.
  - `busy[k]` is cleared by `kernel_done_i[k]`.
  - A done pulse on a non-busy kernel is ignored and sets `spurious_done_o`.
- `kernel_info_o` holds its last issued value between starts.

## Timing
- Reset values:
  - `process_ready_o=1`, `kernel_start_o=0`, `kernel_info_o=0`.
  - `busy_vec_o=0`, `fifo_count_o=0`, `spurious_done_o=0`, counters 0.
  - `rr_ptr=0`, state S_IDLE.
- Latency from an accepted push to `kernel_start_o` is 2 cycles when the FIFO is empty and a kernel is eligible.
- Throughput: at most one dispatch every 2 cycles.
- `process_ready_o` deasserts the cycle after the push that fills the FIFO. It reasserts the cycle after the first pop from full.
- A done pulse clears `busy` at the next edge. The freed kernel can be granted in the cycle after its done pulse.
- Reset asserted mid-operation clears the FIFO, busy state and FSM immediately. Any pulse in flight is cut.

## Configuration
- `MP_DISPATCH_STATS_EN`:
  - Defined: the `dispatch_cnt_o` and `cmpl_cnt_o` 32-bit wrapping counters are implemented. `dispatch_cnt_o` increments on each grant. `cmpl_cnt_o` increments on each non-spurious done, adding the number of done bits set in that cycle.
  - Undefined: both outputs are tied to 0 and no counter flops are built.

## Test plan
- Single job, all kernels idle: push info=88'h0_12_034_00000000_DEAD0000 → `kernel_start_o=8'h01` exactly 2 cycles later, `kernel_info_o` equal to the pushed value, `busy_vec_o=8'h01`.
- Round robin: push 10 jobs with all kernels idle and no done pulses → starts on kernels 0..7 at 2-cycle spacing, then dispatch stalls with `fifo_count_o=2`. A done pulse on kernel 3 → next start on kernel 3.
- Full FIFO: all kernels busy, push 16 jobs → `process_ready_o=0` after the 16th; a 17th held start is not accepted until one pop, then count returns to 16.
- Done on kernel 5 in the same cycle as it would be granted → no grant to 5 that cycle; `busy[5]` clears; grant to 5 allowed next cycle.
- Spurious done on idle kernel 2 → `spurious_done_o=1` sticky, `busy_vec_o` unchanged; reset clears it.
- With `MP_DISPATCH_STATS_EN`: 20 jobs dispatched and completed → `dispatch_cnt_o=20`, `cmpl_cnt_o=20`. Without the macro both read 0.
